// File: rtl/pipe_stage.sv
// pipe_stage: parameterised inter-stage pipeline register for the 5-stage core.
// Each edge the bundle advances, holds or is replaced by an all-zero bubble,
// depending on the global hazard code and on which stage this register feeds.
// An out-of-range STAGE gives a plain always-advancing register.
module pipe_stage #(
  parameter int STAGE = 1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       hazard_signal,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  // Stage codes this register may feed.
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  // Hazard codes from the hazard unit; 7..15 behave as HS_DN.
  localparam logic [3:0] HS_DN        = 4'd0;
  localparam logic [3:0] STALL_EARLY  = 4'd1;
  localparam logic [3:0] FLUSH_EARLY  = 4'd2;
  localparam logic [3:0] FLUSH_ALL    = 4'd3;
  localparam logic [3:0] STALL_MMU    = 4'd4;
  localparam logic [3:0] STALL_SWAP   = 4'd5;
  localparam logic [3:0] FLUSH_EXCEPT = 4'd6;

  typedef enum logic [1:0] {
    ACT_ADV  = 2'd0,
    ACT_HOLD = 2'd1,
    ACT_BUB  = 2'd2
  } act_e;

  // Per-stage action for one hazard code; rows are ID / EX / MEM / WB.
  function automatic act_e stage_action(input logic [3:0] hs);
    act_e a;
    a = ACT_ADV;
    if (STAGE == STAGE_ID) begin
      case (hs)
        STALL_EARLY:  a = ACT_HOLD;
        FLUSH_EARLY:  a = ACT_BUB;
        FLUSH_ALL:    a = ACT_BUB;
        STALL_MMU:    a = ACT_HOLD;
        STALL_SWAP:   a = ACT_HOLD;
        FLUSH_EXCEPT: a = ACT_BUB;
        default:      a = ACT_ADV;
      endcase
    end else if (STAGE == STAGE_EX) begin
      case (hs)
        STALL_EARLY:  a = ACT_BUB;
        FLUSH_ALL:    a = ACT_BUB;
        STALL_MMU:    a = ACT_HOLD;
        STALL_SWAP:   a = ACT_HOLD;
        FLUSH_EXCEPT: a = ACT_BUB;
        default:      a = ACT_ADV;
      endcase
    end else if (STAGE == STAGE_MEM) begin
      case (hs)
        STALL_MMU:    a = ACT_HOLD;
        STALL_SWAP:   a = ACT_BUB;
        FLUSH_EXCEPT: a = ACT_BUB;
        default:      a = ACT_ADV;
      endcase
    end else if (STAGE == STAGE_WB) begin
      case (hs)
        STALL_MMU:    a = ACT_BUB;
        FLUSH_EXCEPT: a = ACT_BUB;
        default:      a = ACT_ADV;
      endcase
    end
    return a;
  endfunction

  // All-zero bundle, read downstream as NOP / no-fault.
  function automatic logic [WIDTH-1:0] bubble();
    return '0;
  endfunction

  act_e             act_p0;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] data_p0;

  // Decode the hazard code into this stage's action.
  always_comb begin
    act_p0 = stage_action(hazard_signal);
  end

  // Select next bundle value from the decoded action.
  always_comb begin
    data_nxt = data_p0;
    case (act_p0)
      ACT_ADV:  data_nxt = in_data;
      ACT_HOLD: data_nxt = data_p0;
      ACT_BUB:  data_nxt = bubble();
      default:  data_nxt = in_data;
    endcase
  end

  // ---- stage boundary: register the bundle; reset overrides every hazard code ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= '0;
    end else begin
      data_p0 <= data_nxt;
    end
  end

  assign out_data = data_p0;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: one instance per stage code plus a plain
// register (STAGE=7) and a narrow WIDTH=8 instance, sharing stimulus.
module tb_pipe_stage;

  logic        clk;
  logic        rst;
  logic [3:0]  hazard_signal;
  logic [31:0] in_data;
  logic [31:0] out_id, out_ex, out_mem, out_wb, out_plain;
  logic [7:0]  out_w8;

  int n_checks;
  int n_fail;

  pipe_stage #(.STAGE(1), .WIDTH(32)) dut_id (
    .clk(clk), .rst(rst), .hazard_signal(hazard_signal), .in_data(in_data), .out_data(out_id));
  pipe_stage #(.STAGE(2), .WIDTH(32)) dut_ex (
    .clk(clk), .rst(rst), .hazard_signal(hazard_signal), .in_data(in_data), .out_data(out_ex));
  pipe_stage #(.STAGE(3), .WIDTH(32)) dut_mem (
    .clk(clk), .rst(rst), .hazard_signal(hazard_signal), .in_data(in_data), .out_data(out_mem));
  pipe_stage #(.STAGE(4), .WIDTH(32)) dut_wb (
    .clk(clk), .rst(rst), .hazard_signal(hazard_signal), .in_data(in_data), .out_data(out_wb));
  pipe_stage #(.STAGE(7), .WIDTH(32)) dut_plain (
    .clk(clk), .rst(rst), .hazard_signal(hazard_signal), .in_data(in_data), .out_data(out_plain));
  pipe_stage #(.STAGE(1), .WIDTH(8)) dut_w8 (
    .clk(clk), .rst(rst), .hazard_signal(hazard_signal), .in_data(in_data[7:0]), .out_data(out_w8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] hs, input logic [31:0] d);
    hazard_signal = hs;
    in_data       = d;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hazard_signal = 4'd0;
    in_data = 32'hFFFF_FFFF;
    step();
    step();
    n_checks++;
    if (out_id !== 32'h0) begin n_fail++; $display("FAIL reset_id got %h want %h", out_id, 32'h0); end
    n_checks++;
    if (out_ex !== 32'h0) begin n_fail++; $display("FAIL reset_ex got %h want %h", out_ex, 32'h0); end
    n_checks++;
    if (out_mem !== 32'h0) begin n_fail++; $display("FAIL reset_mem got %h want %h", out_mem, 32'h0); end
    n_checks++;
    if (out_wb !== 32'h0) begin n_fail++; $display("FAIL reset_wb got %h want %h", out_wb, 32'h0); end
    n_checks++;
    if (out_plain !== 32'h0) begin n_fail++; $display("FAIL reset_plain got %h want %h", out_plain, 32'h0); end
    n_checks++;
    if (out_w8 !== 8'h00) begin n_fail++; $display("FAIL reset_w8 got %h want %h", out_w8, 8'h00); end
    rst = 1'b0;
    drive(4'd0, 32'h0000_00A5);
    n_checks++;
    if (out_w8 !== 8'hA5) begin n_fail++; $display("FAIL release_w8 got %h want %h", out_w8, 8'hA5); end
    n_checks++;
    if (out_id !== 32'h0000_00A5) begin n_fail++; $display("FAIL release_id got %h want %h", out_id, 32'hA5); end
  endtask

  task automatic test_stage_id();
    logic [31:0] vary [3];
    vary[0] = 32'h1111_1111; vary[1] = 32'h2222_2222; vary[2] = 32'h3333_3333;
    drive(4'd0, 32'h1234_5678);
    n_checks++;
    if (out_id !== 32'h1234_5678) begin n_fail++; $display("FAIL id_load got %h want %h", out_id, 32'h12345678); end
    for (int i = 0; i < 3; i++) begin
      drive(4'd1, vary[i]);
      n_checks++;
      if (out_id !== 32'h1234_5678) begin
        n_fail++; $display("FAIL id_stall_early[%0d] got %h want %h", i, out_id, 32'h12345678);
      end
    end
    drive(4'd2, 32'h4444_4444);
    n_checks++;
    if (out_id !== 32'h0) begin n_fail++; $display("FAIL id_flush_early got %h want %h", out_id, 32'h0); end
  endtask

  task automatic test_stage_ex();
    drive(4'd0, 32'hDEAD_BEEF);
    n_checks++;
    if (out_ex !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ex_load got %h want %h", out_ex, 32'hDEADBEEF); end
    drive(4'd1, 32'hCAFE_0001);
    n_checks++;
    if (out_ex !== 32'h0) begin n_fail++; $display("FAIL ex_stall_early got %h want %h", out_ex, 32'h0); end
    drive(4'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      drive(4'd4, 32'hCAFE_0010 + i);
      n_checks++;
      if (out_ex !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL ex_stall_mmu[%0d] got %h want %h", i, out_ex, 32'hDEADBEEF);
      end
    end
    drive(4'd5, 32'hCAFE_0020);
    n_checks++;
    if (out_ex !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ex_stall_swap got %h want %h", out_ex, 32'hDEADBEEF); end
  endtask

  task automatic test_stage_mem();
    drive(4'd0, 32'h1);
    n_checks++;
    if (out_mem !== 32'h1) begin n_fail++; $display("FAIL mem_load got %h want %h", out_mem, 32'h1); end
    drive(4'd3, 32'h2);
    n_checks++;
    if (out_mem !== 32'h2) begin n_fail++; $display("FAIL mem_flush_all got %h want %h", out_mem, 32'h2); end
    drive(4'd5, 32'h9);
    n_checks++;
    if (out_mem !== 32'h0) begin n_fail++; $display("FAIL mem_stall_swap got %h want %h", out_mem, 32'h0); end
    drive(4'd0, 32'h9);
    drive(4'd6, 32'hA);
    n_checks++;
    if (out_mem !== 32'h0) begin n_fail++; $display("FAIL mem_flush_except got %h want %h", out_mem, 32'h0); end
  endtask

  task automatic test_stage_wb();
    drive(4'd0, 32'h55);
    n_checks++;
    if (out_wb !== 32'h55) begin n_fail++; $display("FAIL wb_load got %h want %h", out_wb, 32'h55); end
    drive(4'd4, 32'h5A);
    n_checks++;
    if (out_wb !== 32'h0) begin n_fail++; $display("FAIL wb_stall_mmu got %h want %h", out_wb, 32'h0); end
    drive(4'd5, 32'h66);
    n_checks++;
    if (out_wb !== 32'h66) begin n_fail++; $display("FAIL wb_stall_swap got %h want %h", out_wb, 32'h66); end
    drive(4'hF, 32'h77);
    n_checks++;
    if (out_wb !== 32'h77) begin n_fail++; $display("FAIL wb_code_f got %h want %h", out_wb, 32'h77); end
    // Code 7 on the ID register must advance, like HS_DN.
    drive(4'd7, 32'h88);
    n_checks++;
    if (out_id !== 32'h88) begin n_fail++; $display("FAIL id_code_7 got %h want %h", out_id, 32'h88); end
  endtask

  task automatic test_reset_priority();
    drive(4'd0, 32'hFF);
    n_checks++;
    if (out_ex !== 32'hFF) begin n_fail++; $display("FAIL prio_load got %h want %h", out_ex, 32'hFF); end
    rst = 1'b1;
    drive(4'd4, 32'h11);
    n_checks++;
    if (out_ex !== 32'h0) begin n_fail++; $display("FAIL prio_rst_vs_mmu got %h want %h", out_ex, 32'h0); end
    rst = 1'b0;
    drive(4'd4, 32'h11);
    n_checks++;
    if (out_ex !== 32'h0) begin n_fail++; $display("FAIL prio_hold_after_rst got %h want %h", out_ex, 32'h0); end
    drive(4'd0, 32'h11);
    n_checks++;
    if (out_ex !== 32'h11) begin n_fail++; $display("FAIL prio_adv_after_rst got %h want %h", out_ex, 32'h11); end
  endtask

  task automatic test_plain();
    drive(4'd6, 32'h3);
    n_checks++;
    if (out_plain !== 32'h3) begin n_fail++; $display("FAIL plain_flush_except got %h want %h", out_plain, 32'h3); end
    n_checks++;
    if (out_id !== 32'h0) begin n_fail++; $display("FAIL id_flush_except got %h want %h", out_id, 32'h0); end
    drive(4'd4, 32'h4);
    n_checks++;
    if (out_plain !== 32'h4) begin n_fail++; $display("FAIL plain_stall_mmu got %h want %h", out_plain, 32'h4); end
  endtask

  task automatic test_glitch();
    drive(4'd0, 32'hABCD_0000);
    // Mid-cycle pulse of FLUSH_EXCEPT that is gone again before the edge.
    in_data = 32'hABCD_0001;
    hazard_signal = 4'd6;
    #3;
    hazard_signal = 4'd0;
    step();
    n_checks++;
    if (out_mem !== 32'hABCD_0001) begin n_fail++; $display("FAIL glitch_mem got %h want %h", out_mem, 32'hABCD0001); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [4];
    seq[0] = 32'h0000_0001; seq[1] = 32'h8000_0000; seq[2] = 32'hFFFF_FFFF; seq[3] = 32'h0F0F_F0F0;
    for (int i = 0; i < 4; i++) begin
      drive(4'd0, seq[i]);
      n_checks++;
      if (out_wb !== seq[i]) begin n_fail++; $display("FAIL b2b_wb[%0d] got %h want %h", i, out_wb, seq[i]); end
      n_checks++;
      if (out_w8 !== seq[i][7:0]) begin n_fail++; $display("FAIL b2b_w8[%0d] got %h want %h", i, out_w8, seq[i][7:0]); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    hazard_signal = 4'd0;
    in_data = 32'h0;
    #1;
    test_reset();
    test_stage_id();
    test_stage_ex();
    test_stage_mem();
    test_stage_wb();
    test_reset_priority();
    test_plain();
    test_glitch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
